uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the single-cycle core's data bus, downstream of the core beside data memory. It decodes the core's store/load outputs (MemWrite, ALUResult as address, WriteData) and queues bytes in an internal FIFO. It serialises each byte as 8N1 on `tx` and returns a status word combinationally on `ReadData` so loads complete in the same cycle.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: word-aligned base of the 3-register window.
- `CLK_DIV`, default 868: clk cycles per bit, ≥2.
- `FIFO_DEPTH`, default 8: power of 2, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `MemWrite` in 1: store strobe from the core.
- `ALUResult` in 32: byte address from the core.
- `WriteData` in 32: store data from the core.
- `Sel` out 1: address hits the window; the SoC muxes `ReadData`.
- `ReadData` out 32: register read value, 0 when `Sel`=0.
- `tx` out 1: serial line, idle high.

## Operation
- Decode `ALUResult[31:4]` == `BASE_ADDR[31:4]` and `ALUResult[3:2]`:
  - 0 = TXDATA (W): push `WriteData[7:0]`; reads return 0.
  - 1 = STATUS (R/W):
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[11:8] count, zero-extended; the width is `$clog2(FIFO_DEPTH+1)`, max 4 at the default depth.
    - A write with `WriteData[3]`=1 clears overflow.
  - 2 = CTRL (R/W): bit0 enable, reset value 1.
  - 3 = reserved: reads 0, writes ignored.
- `ReadData`/`Sel` are purely combinational from `ALUResult`. Writes take effect on the clk edge with `MemWrite`&&hit.
- Push acceptance:
  - Accepted if count<`FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- FSM states IDLE, START, DATA, STOP, with bit timer counting 0..`CLK_DIV`-1 and a 3-bit index.
  - IDLE→START when enable && !empty: pop the FIFO head into the shift register in the same cycle.
  - START: `tx`=0 for `CLK_DIV` cycles → DATA.
  - DATA: shift out LSB first, `CLK_DIV` cycles per bit. After bit 7 → STOP.
  - STOP: `tx`=1 for `CLK_DIV` cycles → IDLE.
- Back-to-back bytes: START can follow STOP with one IDLE cycle between frames. Line period per byte = 10·`CLK_DIV`+1 cycles.
- Clearing enable mid-frame: the current frame completes, and the FSM then holds in IDLE; the FIFO is retained.
- `tx` is registered, so there are no glitches.

## Timing
- Reset values:
  - `tx`=1, FSM=IDLE, FIFO empty (count 0), overflow=0, enable=1, timer/index=0.
  - `Sel`/`ReadData` follow the address combinationally.
- Latency from store edge (FIFO and line previously idle):
  - Edge N: push.
  - Edge N+1: pop, START entered, `tx` falls.
  - The start bit begins 1 cycle after the store.
- A read of STATUS in the cycle after a push reflects the new count.
- A simultaneous STATUS overflow-clear and a dropped push leave overflow=1 (set wins).
- `rst` mid-frame: next edge returns `tx`=1, FIFO empty, and the frame is aborted.
- Count wraps never; full and empty are derived from count.

## Structure
- Package `riscv_mmio_pkg` holds:
  - Register offsets (`TXDATA_OFF`=0, `STATUS_OFF`=4, `CTRL_OFF`=8).
  - STATUS bit index constants.
  - `uart_state_t` enum {IDLE, START, DATA, STOP}.
- Sub-module `sync_fifo`:
  - Parameterised width/depth with push, pop, dout, count, full, empty.
  - Same-cycle push+pop allowed when full.
- Top contains the decode, registers and FSM.

## Test plan
All scenarios use `CLK_DIV`=4 and `FIFO_DEPTH`=4.
- Reset, then read STATUS → `ReadData`=0x0000_0002, `tx`=1, `Sel`=1. Address 0x1000 → `Sel`=0, `ReadData`=0.
- Store 0x55 to TXDATA → `tx` pattern 0,1,0,1,0,1,0,1,0,1, each 4 cycles starting 1 cycle after the store. busy=0 after 40 cycles.
- Store 6 bytes back-to-back:
  - First pops immediately; the next 4 fill the FIFO.
  - 6th dropped: STATUS=0x0000_040D (full, busy, overflow).
  - Write STATUS 0x8 → overflow clears.
- CTRL=0, then store 0xA3 → `tx` stays 1, count=1. CTRL=1 → frame starts next cycle.
- Assert `rst` during DATA bit 3 → next edge `tx`=1, STATUS=0x0000_0002.
- With the FIFO full and a pop cycle coinciding with a store → store accepted, count stays 4, overflow=0.

Source files
------------

// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals on the single-cycle core's data bus.
// Holds the UART transmitter register offsets inside its 16-byte window, the STATUS and CTRL
// bit positions, and the transmitter state encoding.
package riscv_mmio_pkg;

   localparam logic [3:0] TXDATA_OFF = 4'h0;
   localparam logic [3:0] STATUS_OFF = 4'h4;
   localparam logic [3:0] CTRL_OFF   = 4'h8;

   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_BUSY_BIT  = 2;
   localparam int STAT_OVF_BIT   = 3;
   localparam int STAT_COUNT_LSB = 8;

   localparam int CTRL_EN_BIT = 0;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output.
// Ports:
//   clk, rst     - clock and synchronous active-high reset (empties the FIFO)
//   push_i/din_i - write request and data; a push into a full FIFO is accepted only
//                  when pop_i is asserted in the same cycle
//   pop_i        - remove the head entry (ignored when empty)
//   dout_o       - current head entry
//   count_o      - occupancy, 0..DEPTH
//   full_o/empty_o - derived from count_o
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rdPtr_q;
   logic [AW-1:0]    wrPtr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             doPush;
   logic             doPop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rdPtr_q];

   // When full, the write slot equals the read slot; the head is read combinationally
   // before the edge, so a simultaneous pop frees the slot the push overwrites.
   assign doPop  = pop_i && !empty_o;
   assign doPush = push_i && (!full_o || doPop);

   always_comb begin
      count_d = count_q;
      if (doPush && !doPop) begin
         count_d = count_q + CW'(1);
      end else if (doPop && !doPush) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         count_q <= count_d;
         if (doPush) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
      end
   end

   // Storage needs no reset: the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= din_i;
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter sitting beside data memory on the core's data bus.
// Stores to TXDATA queue a byte; the FSM pops bytes and serialises them LSB first.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   MemWrite   - store strobe from the core
//   ALUResult  - byte address from the core
//   WriteData  - store data from the core
//   Sel        - address falls inside the 16-byte register window
//   ReadData   - combinational register read value, 0 outside the window
//   tx         - registered serial line, idle high
module uart_tx_mmio
   import riscv_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
   parameter int          CLK_DIV    = 868,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic        Sel,
   output logic [31:0] ReadData,
   output logic        tx
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(CLK_DIV);

   localparam logic [1:0] REG_TXDATA = TXDATA_OFF[3:2];
   localparam logic [1:0] REG_STATUS = STATUS_OFF[3:2];
   localparam logic [1:0] REG_CTRL   = CTRL_OFF[3:2];

   logic [1:0]    regIdx;
   logic          wrTx;
   logic          wrStatus;
   logic          wrCtrl;
   logic          fifoPop;
   logic [7:0]    fifoDout;
   logic [CW-1:0] fifoCount;
   logic          fifoFull;
   logic          fifoEmpty;
   logic          dropped;
   logic [31:0]   statusWord;
   logic          unusedBits;

   uart_state_t   state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          overflow_q, overflow_d;
   logic          enable_q, enable_d;
   logic          timerDone;

   assign Sel      = (ALUResult[31:4] == BASE_ADDR[31:4]);
   assign regIdx   = ALUResult[3:2];
   assign wrTx     = MemWrite && Sel && (regIdx == REG_TXDATA);
   assign wrStatus = MemWrite && Sel && (regIdx == REG_STATUS);
   assign wrCtrl   = MemWrite && Sel && (regIdx == REG_CTRL);

   assign unusedBits = ^{ALUResult[1:0], WriteData[31:8]};

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (wrTx),
      .pop_i  (fifoPop),
      .din_i  (WriteData[7:0]),
      .dout_o (fifoDout),
      .count_o(fifoCount),
      .full_o (fifoFull),
      .empty_o(fifoEmpty)
   );

   // A push is only lost when the FIFO is full and the FSM is not popping in the same cycle.
   assign dropped = wrTx && fifoFull && !fifoPop;

   // Status word assembled from live FIFO/FSM state so a load sees it in the same cycle.
   always_comb begin
      statusWord                             = '0;
      statusWord[STAT_FULL_BIT]              = fifoFull;
      statusWord[STAT_EMPTY_BIT]             = fifoEmpty;
      statusWord[STAT_BUSY_BIT]              = (state_q != IDLE);
      statusWord[STAT_OVF_BIT]               = overflow_q;
      statusWord[STAT_COUNT_LSB +: CW]       = fifoCount;
   end

   // Read mux: TXDATA and the reserved slot read as zero, as does anything outside the window.
   always_comb begin
      ReadData = '0;
      if (Sel) begin
         case (regIdx)
            REG_STATUS: ReadData = statusWord;
            REG_CTRL:   ReadData = {31'b0, enable_q};
            default:    ReadData = '0;
         endcase
      end
   end

   // Set is evaluated after clear so a dropped push in the same cycle keeps overflow high.
   always_comb begin
      overflow_d = overflow_q;
      if (wrStatus && WriteData[STAT_OVF_BIT]) begin
         overflow_d = 1'b0;
      end
      if (dropped) begin
         overflow_d = 1'b1;
      end
      enable_d = wrCtrl ? WriteData[CTRL_EN_BIT] : enable_q;
   end

   assign timerDone = (timer_q == TW'(CLK_DIV - 1));

   // Transmit FSM. tx_d is the line level for the coming cycle, so the registered output
   // changes on the same edge the state does. Enable is only sampled in IDLE, which lets a
   // frame in flight finish after enable is cleared.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      fifoPop = 1'b0;
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (enable_q && !fifoEmpty) begin
               fifoPop = 1'b1;
               shift_d = fifoDout;
               timer_d = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (timerDone) begin
               timer_d = '0;
               idx_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DATA: begin
            if (timerDone) begin
               timer_d = '0;
               if (idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         STOP: begin
            if (timerDone) begin
               timer_d = '0;
               idx_d   = '0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and register file; reset aborts any frame and returns the line to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
         enable_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
         enable_q   <= enable_d;
      end
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLK_DIV=4 and FIFO_DEPTH=4.
// A serial receiver model decodes the line into a queue that is compared with the bytes
// the bench expects to have been accepted; timing-critical scenarios are checked cycle by cycle.
module tb_uart_tx_mmio;

   localparam int          DIV   = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam logic [31:0] A_TX  = BASE;
   localparam logic [31:0] A_ST  = BASE + 32'd4;
   localparam logic [31:0] A_CT  = BASE + 32'd8;
   localparam logic [31:0] A_RS  = BASE + 32'd12;

   logic        clk;
   logic        rst;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic        Sel;
   logic [31:0] ReadData;
   logic        tx;

   int checks = 0;
   int errors = 0;

   logic [7:0] recvQ[$];
   logic [7:0] expQ[$];

   uart_tx_mmio #(
      .BASE_ADDR (BASE),
      .CLK_DIV   (DIV),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .MemWrite (MemWrite),
      .ALUResult(ALUResult),
      .WriteData(WriteData),
      .Sel      (Sel),
      .ReadData (ReadData),
      .tx       (tx)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Receiver model: finds the first low sample of a start bit, then samples each data bit
   // near its middle, assuming DIV cycles per bit.
   initial begin
      logic [7:0] b;
      b = '0;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            repeat (DIV + DIV / 2 - 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               b[i] = tx;
               repeat (DIV) @(negedge clk);
            end
            recvQ.push_back(b);
         end
      end
   end

   // Guard against a hung run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   // Expected STATUS word built from occupancy, activity and overflow.
   function automatic logic [31:0] expStatus(int count, bit busy, bit ovf);
      logic [31:0] w;
      w = 32'(count) << 8;
      if (ovf)            w = w | 32'h8;
      if (busy)           w = w | 32'h4;
      if (count == 0)     w = w | 32'h2;
      if (count == DEPTH) w = w | 32'h1;
      return w;
   endfunction

   // Expected line level for the k-th cycle (1-based) after the store that starts a frame.
   function automatic logic frameBit(logic [7:0] b, int k);
      int pos;
      logic [7:0] v;
      v   = b;
      pos = (k - 1) / DIV;
      if (pos == 0) return 1'b0;
      if (pos >= 9) return 1'b1;
      return v[pos-1];
   endfunction

   task automatic readReg(input logic [31:0] addr, output logic [31:0] data, output logic sel);
      ALUResult = addr;
      #1;
      data = ReadData;
      sel  = Sel;
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      MemWrite  = 1'b1;
      ALUResult = addr;
      WriteData = data;
      @(negedge clk);
      MemWrite = 1'b0;
   endtask

   // Stores bytes to TXDATA on consecutive edges; returns at the negedge after the last store.
   task automatic storeBurst(input logic [7:0] bytes[$]);
      @(negedge clk);
      MemWrite  = 1'b1;
      ALUResult = A_TX;
      foreach (bytes[i]) begin
         WriteData = {24'h0, bytes[i]};
         @(negedge clk);
      end
      MemWrite = 1'b0;
   endtask

   // Polls STATUS until empty and idle or the budget expires; returns the last STATUS seen.
   task automatic waitIdle(input int budget, output logic [31:0] st);
      logic s;
      int n;
      n = 0;
      do begin
         @(negedge clk);
         readReg(A_ST, st, s);
         n++;
      end while (st !== 32'h2 && n < budget);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        s;
      logic [31:0] addr;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      readReg(A_ST, rd, s);
      checks++;
      if (rd !== 32'h2 || s !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_status got=%h sel=%b want=%h sel=1", rd, s, 32'h2);
      end
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_tx got=%b want=1", tx);
      end
      rst = 1'b0;
      @(negedge clk);
      readReg(A_CT, rd, s);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got=%h want=1", rd);
      end
      readReg(A_TX, rd, s);
      checks++;
      if (rd !== 32'h0 || s !== 1'b1) begin
         errors++;
         $display("[TB] FAIL txdata_read got=%h sel=%b want=0 sel=1", rd, s);
      end
      readReg(A_RS, rd, s);
      checks++;
      if (rd !== 32'h0 || s !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reserved_read got=%h sel=%b want=0 sel=1", rd, s);
      end
      readReg(32'h0000_1000, rd, s);
      checks++;
      if (rd !== 32'h0 || s !== 1'b0) begin
         errors++;
         $display("[TB] FAIL outside_1000 got=%h sel=%b want=0 sel=0", rd, s);
      end
      for (int i = 0; i < 4; i++) begin
         addr = $urandom;
         if (addr[31:4] == BASE[31:4]) addr[31] = ~addr[31];
         readReg(addr, rd, s);
         checks++;
         if (rd !== 32'h0 || s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL outside_rand addr=%h got=%h sel=%b want=0 sel=0", addr, rd, s);
         end
      end
   endtask

   task automatic test_single_frame(input logic [7:0] b);
      logic [7:0] q[$];
      logic [31:0] rd;
      logic        s;
      logic        want;
      recvQ.delete();
      q.push_back(b);
      storeBurst(q);
      for (int k = 1; k <= 10 * DIV; k++) begin
         @(negedge clk);
         want = frameBit(b, k);
         checks++;
         if (tx !== want) begin
            errors++;
            $display("[TB] FAIL frame_bit byte=%h cycle=%0d got=%b want=%b", b, k, tx, want);
         end
      end
      @(negedge clk);
      readReg(A_ST, rd, s);
      checks++;
      if (rd !== expStatus(0, 0, 0)) begin
         errors++;
         $display("[TB] FAIL frame_end_status got=%h want=%h", rd, expStatus(0, 0, 0));
      end
      checks++;
      if (recvQ.size() != 1 || recvQ[0] !== b) begin
         errors++;
         $display("[TB] FAIL frame_rx size=%0d want byte=%h", recvQ.size(), b);
      end
   endtask

   task automatic test_overflow();
      logic [7:0]  q[$];
      logic [31:0] rd;
      logic        s;
      recvQ.delete();
      expQ.delete();
      for (int i = 0; i < DEPTH + 2; i++) begin
         q.push_back(8'($urandom));
         if (i < DEPTH + 1) expQ.push_back(q[i]);
      end
      storeBurst(q);
      readReg(A_ST, rd, s);
      checks++;
      if (rd !== expStatus(DEPTH, 1, 1)) begin
         errors++;
         $display("[TB] FAIL overflow_status got=%h want=%h", rd, expStatus(DEPTH, 1, 1));
      end
      busWrite(A_ST, 32'h8);
      readReg(A_ST, rd, s);
      checks++;
      if (rd !== expStatus(DEPTH, 1, 0)) begin
         errors++;
         $display("[TB] FAIL overflow_clear got=%h want=%h", rd, expStatus(DEPTH, 1, 0));
      end
      waitIdle(1000, rd);
      checks++;
      if (rd !== 32'h2) begin
         errors++;
         $display("[TB] FAIL overflow_drain status=%h want=2", rd);
      end
      checks++;
      if (recvQ.size() != expQ.size()) begin
         errors++;
         $display("[TB] FAIL overflow_rx_count got=%0d want=%0d", recvQ.size(), expQ.size());
      end else begin
         foreach (expQ[i]) begin
            checks++;
            if (recvQ[i] !== expQ[i]) begin
               errors++;
               $display("[TB] FAIL overflow_rx idx=%0d got=%h want=%h", i, recvQ[i], expQ[i]);
            end
         end
      end
   endtask

   task automatic test_enable();
      logic [7:0]  q[$];
      logic [31:0] rd;
      logic        s;
      int          highs;
      logic [7:0]  b;
      logic [7:0]  c;
      logic [7:0]  d;
      recvQ.delete();
      busWrite(A_CT, 32'h0);
      readReg(A_CT, rd, s);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("[TB] FAIL ctrl_clear got=%h want=0", rd);
      end
      b = 8'($urandom);
      q.push_back(b);
      storeBurst(q);
      highs = 0;
      repeat (12) begin
         @(negedge clk);
         if (tx === 1'b1) highs++;
      end
      checks++;
      if (highs != 12) begin
         errors++;
         $display("[TB] FAIL disabled_line high_cycles=%0d want=12", highs);
      end
      readReg(A_ST, rd, s);
      checks++;
      if (rd !== expStatus(1, 0, 0)) begin
         errors++;
         $display("[TB] FAIL disabled_status got=%h want=%h", rd, expStatus(1, 0, 0));
      end
      @(negedge clk);
      MemWrite  = 1'b1;
      ALUResult = A_CT;
      WriteData = 32'h1;
      @(negedge clk);
      MemWrite = 1'b0;
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("[TB] FAIL enable_edge_tx got=%b want=1", tx);
      end
      @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("[TB] FAIL enable_start_tx got=%b want=0", tx);
      end
      waitIdle(200, rd);
      checks++;
      if (rd !== 32'h2 || recvQ.size() != 1 || recvQ[0] !== b) begin
         errors++;
         $display("[TB] FAIL enable_rx status=%h size=%0d want byte=%h", rd, recvQ.size(), b);
      end
      recvQ.delete();
      q.delete();
      c = 8'($urandom);
      d = 8'($urandom);
      q.push_back(c);
      q.push_back(d);
      storeBurst(q);
      repeat (10) @(negedge clk);
      busWrite(A_CT, 32'h0);
      repeat (60) @(negedge clk);
      readReg(A_ST, rd, s);
      checks++;
      if (rd !== expStatus(1, 0, 0) || tx !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midframe_disable status=%h tx=%b want=%h tx=1", rd, tx, expStatus(1, 0, 0));
      end
      checks++;
      if (recvQ.size() != 1 || recvQ[0] !== c) begin
         errors++;
         $display("[TB] FAIL midframe_disable_rx size=%0d want byte=%h", recvQ.size(), c);
      end
      busWrite(A_CT, 32'h1);
      waitIdle(200, rd);
      checks++;
      if (rd !== 32'h2 || recvQ.size() != 2 || recvQ[recvQ.size()-1] !== d) begin
         errors++;
         $display("[TB] FAIL reenable_rx status=%h size=%0d want byte=%h", rd, recvQ.size(), d);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0]  q[$];
      logic [31:0] rd;
      logic        s;
      int          highs;
      for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
      storeBurst(q);
      repeat (4 * DIV + 2 - 3 + 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midframe_reset_tx got=%b want=1", tx);
      end
      readReg(A_ST, rd, s);
      checks++;
      if (rd !== 32'h2) begin
         errors++;
         $display("[TB] FAIL midframe_reset_status got=%h want=2", rd);
      end
      rst = 1'b0;
      highs = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx === 1'b1) highs++;
      end
      checks++;
      if (highs != 60) begin
         errors++;
         $display("[TB] FAIL after_reset_line high_cycles=%0d want=60", highs);
      end
      recvQ.delete();
   endtask

   task automatic test_full_pop_store();
      logic [7:0]  q[$];
      logic [31:0] rd;
      logic        s;
      logic [7:0]  f;
      recvQ.delete();
      expQ.delete();
      for (int i = 0; i < DEPTH + 1; i++) begin
         q.push_back(8'($urandom));
         expQ.push_back(q[i]);
      end
      storeBurst(q);
      repeat (10 * DIV + 1 - DEPTH) @(negedge clk);
      readReg(A_ST, rd, s);
      checks++;
      if (rd !== expStatus(DEPTH, 0, 0)) begin
         errors++;
         $display("[TB] FAIL pre_pop_status got=%h want=%h", rd, expStatus(DEPTH, 0, 0));
      end
      f = 8'($urandom);
      expQ.push_back(f);
      MemWrite  = 1'b1;
      ALUResult = A_TX;
      WriteData = {24'h0, f};
      @(negedge clk);
      MemWrite = 1'b0;
      readReg(A_ST, rd, s);
      checks++;
      if (rd !== expStatus(DEPTH, 1, 0)) begin
         errors++;
         $display("[TB] FAIL pop_store_status got=%h want=%h", rd, expStatus(DEPTH, 1, 0));
      end
      waitIdle(1000, rd);
      checks++;
      if (rd !== 32'h2) begin
         errors++;
         $display("[TB] FAIL pop_store_drain status=%h want=2", rd);
      end
      checks++;
      if (recvQ.size() != expQ.size()) begin
         errors++;
         $display("[TB] FAIL pop_store_rx_count got=%0d want=%0d", recvQ.size(), expQ.size());
      end else begin
         foreach (expQ[i]) begin
            checks++;
            if (recvQ[i] !== expQ[i]) begin
               errors++;
               $display("[TB] FAIL pop_store_rx idx=%0d got=%h want=%h", i, recvQ[i], expQ[i]);
            end
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      MemWrite  = 1'b0;
      ALUResult = '0;
      WriteData = '0;
      test_reset();
      test_single_frame(8'h55);
      test_single_frame(8'($urandom));
      test_overflow();
      test_enable();
      test_reset_midframe();
      test_full_pop_store();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
